cargador_programa: RTL and testbench
====================================

Name: cargador_programa

Overview:
- Receive-side program loader for the MIPS debug link.
- Sits between the UART receiver and the MIPS instruction RAM, in the host-to-board direction; the opposite direction is the register/latch dump.
- Assembles incoming UART bytes into LEN-bit instruction words and writes them sequentially into instruction memory.
- Stops on a HALT word or when memory is full, then answers the host with a one-byte ACK/NACK through the UART transmitter.

Parameters:
- LEN, 32, instruction word width; must be a multiple of LEN_DATA.
- LEN_DATA, 8, UART byte width.
- cant_instrucciones, 64, instruction RAM depth in words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to RAM.
- ACK_BYTE, 8'h06, reply byte on success.
- NACK_BYTE, 8'h15, reply byte on overflow or checksum error.

Ports:
- clk  input  1  system clock; same domain as the UART.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE.
- rx_done  input  1  one-cycle pulse; uart_data_in is valid in that cycle.
- uart_data_in  input  LEN_DATA  received byte.
- tx_done  input  1  one-cycle pulse; transmitter has finished the current byte.
- tx_start  output  1  one-cycle pulse requesting transmission of uart_data_out.
- uart_data_out  output  LEN_DATA  reply byte; held stable from tx_start until tx_done.
- addr_mem_inst  output  $clog2(cant_instrucciones)  instruction RAM write address.
- ins_to_mem  output  LEN  instruction RAM write data.
- write_enable_ram_inst  output  1  one-cycle write strobe.
- busy  output  1  high from the start acceptance until DONE.
- done  output  1  one-cycle pulse when the reply byte has been sent.
- error  output  1  sticky; set with a NACK reply; cleared on the next accepted start.
- word_count  output  $clog2(cant_instrucciones)+1  number of words written in the current load.

Behaviour:
- Reset (reset==0): state IDLE; every output 0, including the address, data, counters, byte index and checksum accumulator.
- A reset in any state, including mid-word or mid-reply, aborts without any further RAM write. A tx_done that arrives after reset is ignored.
- States: IDLE, RECV, WRITE, CHECK, SEND, WAIT_TX, DONE.
- IDLE:
  - start -> RECV, busy=1.
  - Clear word_count, addr_mem_inst, byte index, error and checksum.
- RECV:
  - Each rx_done shifts uart_data_in into the word register, MSB byte first: word <= {word[LEN-LEN_DATA-1:0], byte}.
  - The byte index counts 0..LEN/LEN_DATA-1.
  - When the last byte arrives -> WRITE on the next cycle.
  - Cycles without rx_done hold state; there is no timeout.
- WRITE (exactly one cycle):
  - write_enable_ram_inst=1, ins_to_mem=word, addr_mem_inst = current address.
  - In the following cycle: address +1, word_count +1, byte index = 0.
  - If word==HALT_WORD -> CHECK.
  - Else if the written address was cant_instrucciones-1 -> set error, SEND (overflow; the last word is still written).
  - Else -> RECV.
  - Latency: the strobe occurs 1 cycle after the rx_done of the final byte.
- CHECK: without the optional feature this state passes straight to SEND in one cycle.
- SEND (one cycle):
  - uart_data_out = error ? NACK_BYTE : ACK_BYTE, tx_start=1 -> WAIT_TX.
- WAIT_TX: wait for tx_done -> DONE. A tx_done in the same cycle as tx_start is not counted.
- DONE (one cycle): done=1, busy=0 -> IDLE.
- rx_done is ignored outside RECV (and outside CHECK when the checksum feature is on); bytes are neither buffered nor counted.
- start is ignored while busy.
- Addresses never wrap: the full condition ends the load before any wrap can occur.
- A HALT word written at the last address is a success (ACK), not an overflow.

Optional Feature:
- Macro CARGADOR_CHECKSUM_EN.
- When defined:
  - Every byte received in RECV is XORed into an 8-bit accumulator.
  - In CHECK the block waits for one further rx_done byte.
  - If that byte differs from the accumulator, error is set.
  - It then goes to SEND; the reply is NACK on mismatch, ACK otherwise.
  - On overflow, CHECK is skipped.
- When undefined: no accumulator is built; CHECK lasts one cycle and the reply depends only on overflow.

Test Plan:
- Reset mid-word: release reset, start, send 2 bytes, pull reset low for 1 cycle -> all outputs 0, no write strobe. A new start then loads at address 0.
- Two-word load: start, send 0x20,0x01,0x00,0x05, then 0xFF×4 -> write @0 = 0x20010005, write @1 = 0xFFFFFFFF, each strobe 1 cycle after the 4th rx_done. Then tx_start with 0x06, tx_done, done pulse, word_count = 2, error = 0.
- Overflow, cant_instrucciones=4: send 4 non-HALT words -> 4 writes at addresses 0..3, then NACK 0x15, error = 1, no fifth write. Further bytes are ignored.
- Ignored inputs: rx_done pulses while IDLE and a start pulse during RECV -> no writes, no state change, byte index unchanged.
- Transmit handshake: hold tx_done low for 100 cycles after tx_start -> uart_data_out stays stable, tx_start is a single pulse, done fires only after tx_done.
- With CARGADOR_CHECKSUM_EN, the HALT-only program (0xFF×4):
  - Checksum 0x00 -> ACK.
  - Checksum 0x01 -> NACK, error = 1.
  - A new start clears error.

Source files
------------

// File: rtl/cargador_programa_if.sv
// Bus bundle between the program loader and its surroundings: UART receive and transmit
// handshakes, the instruction RAM write port, and the load status outputs.
//
// Modports:
//   master - the loader. It drives the RAM write port, the transmit request and the status.
//   slave  - the environment (UART, instruction RAM, debug controller) facing the loader.
//
// Signals:
//   start                 one-cycle pulse that begins a load
//   rx_done, uart_data_in received byte strobe and data
//   tx_done               transmitter finished the current byte
//   tx_start              request to transmit uart_data_out
//   uart_data_out         reply byte (ACK/NACK)
//   addr_mem_inst         instruction RAM write address
//   ins_to_mem            instruction RAM write data
//   write_enable_ram_inst instruction RAM write strobe
//   busy, done, error     load status
//   word_count            number of words written in the current load
interface cargador_programa_if #(
  parameter int unsigned LEN                = 32,
  parameter int unsigned LEN_DATA           = 8,
  parameter int unsigned cant_instrucciones = 64
);
  localparam int unsigned AW = $clog2(cant_instrucciones);

  logic                start;
  logic                rx_done;
  logic [LEN_DATA-1:0] uart_data_in;
  logic                tx_done;
  logic                tx_start;
  logic [LEN_DATA-1:0] uart_data_out;
  logic [AW-1:0]       addr_mem_inst;
  logic [LEN-1:0]      ins_to_mem;
  logic                write_enable_ram_inst;
  logic                busy;
  logic                done;
  logic                error;
  logic [AW:0]         word_count;

  modport master (
    input  start,
    input  rx_done,
    input  uart_data_in,
    input  tx_done,
    output tx_start,
    output uart_data_out,
    output addr_mem_inst,
    output ins_to_mem,
    output write_enable_ram_inst,
    output busy,
    output done,
    output error,
    output word_count
  );

  modport slave (
    output start,
    output rx_done,
    output uart_data_in,
    output tx_done,
    input  tx_start,
    input  uart_data_out,
    input  addr_mem_inst,
    input  ins_to_mem,
    input  write_enable_ram_inst,
    input  busy,
    input  done,
    input  error,
    input  word_count
  );
endinterface

// File: rtl/cargador_programa.sv
// Receive-side program loader for the MIPS debug link.
//
// Takes bytes from the UART receiver, assembles them MSB byte first into LEN-bit instruction
// words and writes them to consecutive instruction RAM addresses starting at 0. The load ends
// when a HALT_WORD has been written (success, ACK_BYTE reply) or when the last RAM address has
// been written with a non-HALT word (overflow, NACK_BYTE reply, error set). The reply byte is
// sent through the UART transmitter and a done pulse closes the load.
//
// Optional feature: define CARGADOR_CHECKSUM_EN to build an XOR checksum over every byte
// received while loading. After HALT the loader waits for one more byte and compares it with
// the accumulator; a mismatch turns the reply into NACK_BYTE and sets error. Overflow skips
// the checksum byte entirely.
//
// Ports:
//   clk    system clock, shared with the UART
//   reset  synchronous active-low reset
//   bus    cargador_programa_if.master (UART handshakes, RAM write port, status)
//
// The interface instance must be built with the same LEN, LEN_DATA and cant_instrucciones.
// LEN must be a multiple of LEN_DATA and larger than it.
module cargador_programa #(
  parameter int unsigned         LEN                = 32,
  parameter int unsigned         LEN_DATA           = 8,
  parameter int unsigned         cant_instrucciones = 64,
  parameter logic [LEN-1:0]      HALT_WORD          = {LEN{1'b1}},
  parameter logic [LEN_DATA-1:0] ACK_BYTE           = LEN_DATA'(8'h06),
  parameter logic [LEN_DATA-1:0] NACK_BYTE          = LEN_DATA'(8'h15)
) (
  input logic                 clk,
  input logic                 reset,
  cargador_programa_if.master bus
);

  localparam int unsigned AW = $clog2(cant_instrucciones);
  localparam int unsigned NB = LEN / LEN_DATA;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [AW-1:0] LastAddr = AW'(cant_instrucciones - 1);
  localparam logic [IW-1:0] LastIdx  = IW'(NB - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StSend,
    StWaitTx,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [LEN-1:0] word_q, word_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW:0]    count_q, count_d;
  logic           error_q, error_d;
`ifdef CARGADOR_CHECKSUM_EN
  logic [LEN_DATA-1:0] chk_q, chk_d;
`endif

  // State register. Reset is synchronous so an abort mid-word simply discards the partial
  // word: the WRITE state can never be reached from the reset value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      error_q <= error_d;
`ifdef CARGADOR_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
`ifdef CARGADOR_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      StIdle: begin
        // start is only honoured here, which is what makes it ignored while busy.
        if (bus.start) begin
          state_d = StRecv;
          idx_d   = '0;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end

      StRecv: begin
        if (bus.rx_done) begin
          word_d = {word_q[LEN-LEN_DATA-1:0], bus.uart_data_in};
`ifdef CARGADOR_CHECKSUM_EN
          chk_d  = chk_q ^ bus.uart_data_in;
`endif
          if (idx_q == LastIdx) begin
            state_d = StWrite;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      StWrite: begin
        idx_d   = '0;
        count_d = count_q + 1'b1;
        // Saturate at the last address so the pointer never wraps back to 0; a load that
        // reaches it always terminates in this state.
        if (addr_q != LastAddr) begin
          addr_d = addr_q + 1'b1;
        end
        if (word_q == HALT_WORD) begin
          state_d = StCheck;
        end else if (addr_q == LastAddr) begin
          error_d = 1'b1;
          state_d = StSend;
        end else begin
          state_d = StRecv;
        end
      end

      StCheck: begin
`ifdef CARGADOR_CHECKSUM_EN
        if (bus.rx_done) begin
          if (bus.uart_data_in != chk_q) begin
            error_d = 1'b1;
          end
          state_d = StSend;
        end
`else
        state_d = StSend;
`endif
      end

      StSend: begin
        state_d = StWaitTx;
      end

      // Only tx_done seen from here on counts, so a pulse coincident with tx_start is dropped.
      StWaitTx: begin
        if (bus.tx_done) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign bus.write_enable_ram_inst = (state_q == StWrite);
  assign bus.addr_mem_inst         = addr_q;
  assign bus.ins_to_mem            = word_q;
  assign bus.tx_start              = (state_q == StSend);
  // error_q is settled before SEND and cannot change until the next start, so the reply byte
  // stays stable through WAIT_TX without a dedicated holding register.
  assign bus.uart_data_out         = (state_q == StSend || state_q == StWaitTx) ?
                                     (error_q ? NACK_BYTE : ACK_BYTE) : '0;
  assign bus.busy                  = (state_q != StIdle) && (state_q != StDone);
  assign bus.done                  = (state_q == StDone);
  assign bus.error                 = error_q;
  assign bus.word_count            = count_q;

endmodule

// File: tb/tb_cargador_programa.sv
module tb_cargador_programa;

  localparam int unsigned CANT = 4;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [2:0] wc;
    logic       err;
  } done_t;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } chk_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   rel_cnt;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  done_t      exp_done[$];
  chk_t       exp_chk[$];

  cargador_programa_if #(.LEN(32), .LEN_DATA(8), .cant_instrucciones(CANT)) bus ();

  cargador_programa #(.cant_instrucciones(CANT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1);
  end

  function automatic logic [31:0] actual(input int k);
    case (k)
      0:       return 32'(bus.busy);
      1:       return 32'(bus.done);
      2:       return 32'(bus.error);
      3:       return 32'(bus.word_count);
      4:       return 32'(bus.addr_mem_inst);
      5:       return bus.ins_to_mem;
      6:       return 32'(bus.uart_data_out);
      7:       return 32'(bus.tx_start);
      8:       return 32'(bus.write_enable_ram_inst);
      9:       return 32'd1;
      10:      return 32'(exp_wr.size());
      11:      return 32'(exp_tx.size());
      12:      return 32'(exp_done.size());
      default: return 32'hdeadbeef;
    endcase
  endfunction

  // Monitor: the only process that counts comparisons and failures.
  initial begin : monitor
    wr_t         w;
    done_t       dd;
    chk_t        c;
    logic [7:0]  eb;
    logic [7:0]  held;
    logic [31:0] act;
    bit          in_tx;
    bit          stable;
    int          done_seen;
    checks    = 0;
    errors    = 0;
    in_tx     = 0;
    stable    = 0;
    done_seen = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      while (exp_chk.size() > 0) begin
        c = exp_chk.pop_front();
        checks++;
        act = actual(c.kind);
        if (act !== c.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.val);
        end
      end
      if (bus.write_enable_ram_inst) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr %0d data %h, expected no write",
                   bus.addr_mem_inst, bus.ins_to_mem);
        end else begin
          w = exp_wr.pop_front();
          if (bus.addr_mem_inst !== w.addr || bus.ins_to_mem !== w.data || cyc != w.cyc) begin
            errors++;
            $display("FAIL write: got addr %0d data %h cycle %0d, expected addr %0d data %h cycle %0d",
                     bus.addr_mem_inst, bus.ins_to_mem, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      if (bus.tx_start) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_start_unexpected: got byte %h, expected no tx_start", bus.uart_data_out);
        end else begin
          eb = exp_tx.pop_front();
          if (bus.uart_data_out !== eb) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", bus.uart_data_out, eb);
          end
        end
        in_tx  = 1;
        stable = 1;
        held   = bus.uart_data_out;
      end else if (in_tx && !bus.done && bus.uart_data_out !== held) begin
        stable = 0;
      end
      if (bus.done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done, expected none");
        end else begin
          dd = exp_done.pop_front();
          if (bus.word_count !== dd.wc || bus.error !== dd.err || !(in_tx && stable) ||
              rel_cnt != done_seen + 1) begin
            errors++;
            $display("FAIL done: got wc %0d err %0d stable %0d releases %0d, expected wc %0d err %0d stable 1 releases %0d",
                     bus.word_count, bus.error, in_tx && stable, rel_cnt, dd.wc, dd.err,
                     done_seen + 1);
          end
        end
        done_seen++;
        in_tx = 0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_sig(input int kind, input logic [31:0] val, input string name);
    chk_t c;
    c.kind = kind;
    c.val  = val;
    c.name = name;
    exp_chk.push_back(c);
  endtask

  task automatic expect_idle_zero(input string tag);
    sync();
    expect_sig(0, 0, {tag, "_busy"});
    expect_sig(1, 0, {tag, "_done"});
    expect_sig(2, 0, {tag, "_error"});
    expect_sig(3, 0, {tag, "_word_count"});
    expect_sig(4, 0, {tag, "_addr"});
    expect_sig(5, 0, {tag, "_ins_to_mem"});
    expect_sig(6, 0, {tag, "_uart_data_out"});
    expect_sig(7, 0, {tag, "_tx_start"});
    expect_sig(8, 0, {tag, "_write_enable"});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp, input logic [1:0] a,
                           input logic [31:0] w);
    wr_t e;
    @(negedge clk);
    bus.rx_done      = 1'b1;
    bus.uart_data_in = b;
    if (exp) begin
      e.addr = a;
      e.data = w;
      e.cyc  = cyc + 1;
      exp_wr.push_back(e);
    end
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit exp, input logic [1:0] a);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], exp && (i == 3), a, w);
    end
  endtask

  task automatic push_reply(input logic [7:0] b, input logic [2:0] wc, input logic err);
    done_t d;
    d.wc  = wc;
    d.err = err;
    exp_tx.push_back(b);
    exp_done.push_back(d);
  endtask

  // Waits for tx_start; optionally pulses tx_done in that same cycle, which must be ignored.
  task automatic wait_tx(input bit early, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.tx_start) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      expect_sig(9, 0, "tx_start_timeout");
    end else if (early) begin
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic release_tx(input int hold);
    repeat (hold) @(negedge clk);
    bus.tx_done = 1'b1;
    rel_cnt++;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reply(input logic [7:0] b, input logic [2:0] wc, input logic err,
                       input int hold, input bit early);
    bit ok;
    push_reply(b, wc, err);
    wait_tx(early, ok);
    if (ok) release_tx(hold);
  endtask

  initial begin : driver
    bit ok;
    rel_cnt          = 0;
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.rx_done      = 1'b0;
    bus.uart_data_in = '0;
    bus.tx_done      = 1'b0;
    repeat (2) @(negedge clk);
    expect_idle_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a word, then a clean HALT-only load from address 0.
    pulse_start();
    sync();
    expect_sig(0, 1, "busy_after_start");
    send_byte(8'h12, 0, 0, 0);
    send_byte(8'h34, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect_idle_zero("midword_reset");
    pulse_start();
    send_word(32'hFFFFFFFF, 1, 2'd0);
`ifdef CARGADOR_CHECKSUM_EN
    send_byte(8'h00, 0, 0, 0);
`endif
    reply(8'h06, 3'd1, 1'b0, 3, 0);

    // Two-word load with a long transmitter stall and a tx_done coincident with tx_start.
    pulse_start();
    send_word(32'h20010005, 1, 2'd0);
    send_word(32'hFFFFFFFF, 1, 2'd1);
`ifdef CARGADOR_CHECKSUM_EN
    send_byte(8'h24, 0, 0, 0);
`endif
    reply(8'h06, 3'd2, 1'b0, 100, 1);
    sync();
    expect_sig(3, 2, "two_word_count");
    expect_sig(2, 0, "two_word_error");
    expect_sig(0, 0, "two_word_busy");

    // Overflow: four non-HALT words fill the RAM; a fifth word arriving during the reply and
    // another one while idle must not be written.
    pulse_start();
    send_word(32'h11111111, 1, 2'd0);
    send_word(32'h22222222, 1, 2'd1);
    send_word(32'h33333333, 1, 2'd2);
    send_word(32'h44444444, 1, 2'd3);
    push_reply(8'h15, 3'd4, 1'b1);
    wait_tx(0, ok);
    send_word(32'h55555555, 0, 2'd0);
    if (ok) release_tx(2);
    send_word(32'h66666666, 0, 2'd0);
    sync();
    expect_sig(2, 1, "overflow_error_sticky");
    expect_sig(0, 0, "overflow_idle_busy");
    expect_sig(3, 4, "overflow_word_count");

    // New start clears error; a start pulse mid-word is ignored.
    pulse_start();
    sync();
    expect_sig(2, 0, "start_clears_error");
    expect_sig(0, 1, "busy_second_start");
    send_byte(8'hA5, 0, 0, 0);
    send_byte(8'hA5, 0, 0, 0);
    pulse_start();
    send_byte(8'h5A, 0, 0, 0);
    send_byte(8'h5A, 1, 2'd0, 32'hA5A55A5A);
    send_word(32'hFFFFFFFF, 1, 2'd1);
`ifdef CARGADOR_CHECKSUM_EN
    send_byte(8'h00, 0, 0, 0);
`endif
    reply(8'h06, 3'd2, 1'b0, 4, 0);

`ifdef CARGADOR_CHECKSUM_EN
    // Bad checksum on a HALT-only program, then a good one after a fresh start.
    pulse_start();
    send_word(32'hFFFFFFFF, 1, 2'd0);
    send_byte(8'h01, 0, 0, 0);
    reply(8'h15, 3'd1, 1'b1, 3, 0);
    sync();
    expect_sig(2, 1, "checksum_error");
    pulse_start();
    sync();
    expect_sig(2, 0, "checksum_error_cleared");
    send_word(32'hFFFFFFFF, 1, 2'd0);
    send_byte(8'h00, 0, 0, 0);
    reply(8'h06, 3'd1, 1'b0, 3, 0);
`endif

    repeat (5) @(negedge clk);
    sync();
    expect_sig(10, 0, "pending_writes");
    expect_sig(11, 0, "pending_tx");
    expect_sig(12, 0, "pending_done");
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
